// File: rtl/rv32i_defs.sv
`default_nettype none
// ============================================================================
// rv32i_defs: ALU op codes, base opcodes and immediate formats.   Rev 1.0
// ============================================================================
package rv32i_defs;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   // instruction[6:2]; bits [1:0] must be 2'b11 for a 32-bit encoding
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/rv32i_imm_decode.sv
`default_nettype none
// ============================================================================
// rv32i_imm_decode: sign-extended immediate extraction by format.   Rev 1.0
// ============================================================================
module rv32i_imm_decode
   import rv32i_defs::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr_i,
   input  imm_fmt_e        fmt_i,
   output logic [XLEN-1:0] imm_o
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (fmt_i)
         IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   imm32 = {instr_i[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm_o = XLEN'($signed(imm32));
   end

endmodule
`default_nettype wire

// File: rtl/rv32i_decode_pipe.sv
`default_nettype none
// ============================================================================
// rv32i_decode_pipe: decode/issue stage with RAW busy scoreboard.   Rev 1.0
// ============================================================================
module rv32i_decode_pipe
   import rv32i_defs::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            data_ready_i,
   input  logic [31:0]     instruction_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            stall_o,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            wb_valid_i,
   input  logic [4:0]      wb_rd_i,
   output logic            data_ready_o,
   output logic [3:0]      operation_o,
   output logic [XLEN-1:0] operand1_o,
   output logic [XLEN-1:0] operand2_o,
   output logic [4:0]      rd_o,
   output logic [4:0]      opcode_o,
   output logic [2:0]      funct3_o,
   output logic [XLEN-1:0] store_data_o,
   output logic [XLEN-1:0] imm_o,
   output logic [XLEN-1:0] pc_o,
   output logic            illegal_o,
   input  logic            clear_i
);

   logic [4:0]      opcode;
   logic [2:0]      funct3;
   logic            is_rv32;
   imm_fmt_e        imm_fmt;
   logic [XLEN-1:0] imm;
   logic [3:0]      op_dec;
   logic [XLEN-1:0] op1_dec, op2_dec;
   logic [4:0]      rd_dec;
   logic            rs1_used, rs2_used, illegal_dec;
   logic            issue;

   logic [REG_COUNT-1:0] busy_q, busy_d;
   logic            hist_a_valid_q, hist_a_valid_d, hist_b_valid_q, hist_b_valid_d;
   logic [4:0]      hist_a_rd_q, hist_a_rd_d, hist_b_rd_q, hist_b_rd_d;

   logic            data_ready_q, data_ready_d, illegal_q, illegal_d;
   logic [3:0]      operation_q, operation_d;
   logic [4:0]      rd_q, rd_d, opcode_q, opcode_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] operand1_q, operand1_d, operand2_q, operand2_d;
   logic [XLEN-1:0] store_data_q, store_data_d, imm_q, imm_d, pc_q, pc_d;

   assign opcode     = instruction_i[6:2];
   assign funct3     = instruction_i[14:12];
   assign is_rv32    = (instruction_i[1:0] == 2'b11);
   assign rs1_addr_o = instruction_i[19:15];
   assign rs2_addr_o = instruction_i[24:20];

   always_comb begin
      imm_fmt = IMM_NONE;
      if (is_rv32) begin
         case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt = IMM_I;
            OPC_STORE:                      imm_fmt = IMM_S;
            OPC_BRANCH:                     imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
            OPC_JAL:                        imm_fmt = IMM_J;
            default:                        imm_fmt = IMM_NONE;
         endcase
      end
   end

   rv32i_imm_decode #(.XLEN(XLEN)) u_imm_decode (
      .instr_i (instruction_i[31:7]),
      .fmt_i   (imm_fmt),
      .imm_o   (imm)
   );

   always_comb begin
      op_dec      = ALU_ADD;
      op1_dec     = '0;
      op2_dec     = '0;
      rd_dec      = instruction_i[11:7];
      rs1_used    = 1'b1;
      rs2_used    = 1'b0;
      illegal_dec = 1'b0;
      case ({is_rv32, opcode})
         {1'b1, OPC_OP}: begin
            op_dec   = {instruction_i[30], funct3};
            op1_dec  = rs1_data_i;
            op2_dec  = rs2_data_i;
            rs2_used = 1'b1;
         end
         // shift-immediates hand the ALU a clean shamt rather than the raw imm field
         {1'b1, OPC_OP_IMM}: begin
            op_dec  = {(funct3 == 3'b101) & instruction_i[30], funct3};
            op1_dec = rs1_data_i;
            op2_dec = (funct3[1:0] == 2'b01) ? XLEN'(instruction_i[24:20]) : imm;
         end
         {1'b1, OPC_LUI}: begin
            op2_dec  = imm;
            rs1_used = 1'b0;
         end
         {1'b1, OPC_AUIPC}: begin
            op1_dec  = pc_i;
            op2_dec  = imm;
            rs1_used = 1'b0;
         end
         {1'b1, OPC_JAL}: begin
            op1_dec  = pc_i;
            op2_dec  = XLEN'(4);
            rs1_used = 1'b0;
         end
         {1'b1, OPC_JALR}: begin
            op1_dec = pc_i;
            op2_dec = XLEN'(4);
         end
         {1'b1, OPC_BRANCH}: begin
            op_dec   = ALU_SUB;
            op1_dec  = rs1_data_i;
            op2_dec  = rs2_data_i;
            rd_dec   = '0;
            rs2_used = 1'b1;
         end
         {1'b1, OPC_LOAD}: begin
            op1_dec = rs1_data_i;
            op2_dec = imm;
         end
         {1'b1, OPC_STORE}: begin
            op1_dec  = rs1_data_i;
            op2_dec  = imm;
            rd_dec   = '0;
            rs2_used = 1'b1;
         end
         default: begin
            rd_dec      = '0;
            illegal_dec = 1'b1;
         end
      endcase
   end

   // busy_q is the registered view: a writeback landing this cycle does not unblock yet
   assign stall_o = data_ready_i & ~clear_i &
                    ((rs1_used & (rs1_addr_o != 5'd0) & busy_q[rs1_addr_o]) |
                     (rs2_used & (rs2_addr_o != 5'd0) & busy_q[rs2_addr_o]));
   assign issue   = data_ready_i & ~stall_o & ~clear_i;

   always_comb begin
      busy_d = busy_q;
      if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
      if (clear_i) begin
         if (hist_a_valid_q) busy_d[hist_a_rd_q] = 1'b0;
         if (hist_b_valid_q) busy_d[hist_b_rd_q] = 1'b0;
      end
      if (issue && (rd_dec != 5'd0)) busy_d[rd_dec] = 1'b1;
      busy_d[0] = 1'b0;

      hist_a_valid_d = issue;
      hist_a_rd_d    = rd_dec;
      hist_b_valid_d = hist_a_valid_q & ~clear_i;
      hist_b_rd_d    = hist_a_rd_q;
   end

   always_comb begin
      data_ready_d = issue;
      operation_d  = operation_q;
      operand1_d   = operand1_q;
      operand2_d   = operand2_q;
      rd_d         = rd_q;
      opcode_d     = opcode_q;
      funct3_d     = funct3_q;
      store_data_d = store_data_q;
      imm_d        = imm_q;
      pc_d         = pc_q;
      illegal_d    = illegal_q;
      if (issue) begin
         operation_d  = op_dec;
         operand1_d   = op1_dec;
         operand2_d   = op2_dec;
         rd_d         = rd_dec;
         opcode_d     = opcode;
         funct3_d     = funct3;
         store_data_d = rs2_data_i;
         imm_d        = imm;
         pc_d         = pc_i;
         illegal_d    = illegal_dec;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q         <= '0;
         hist_a_valid_q <= 1'b0;
         hist_a_rd_q    <= '0;
         hist_b_valid_q <= 1'b0;
         hist_b_rd_q    <= '0;
         data_ready_q   <= 1'b0;
         operation_q    <= '0;
         operand1_q     <= '0;
         operand2_q     <= '0;
         rd_q           <= '0;
         opcode_q       <= '0;
         funct3_q       <= '0;
         store_data_q   <= '0;
         imm_q          <= '0;
         pc_q           <= '0;
         illegal_q      <= 1'b0;
      end else begin
         busy_q         <= busy_d;
         hist_a_valid_q <= hist_a_valid_d;
         hist_a_rd_q    <= hist_a_rd_d;
         hist_b_valid_q <= hist_b_valid_d;
         hist_b_rd_q    <= hist_b_rd_d;
         data_ready_q   <= data_ready_d;
         operation_q    <= operation_d;
         operand1_q     <= operand1_d;
         operand2_q     <= operand2_d;
         rd_q           <= rd_d;
         opcode_q       <= opcode_d;
         funct3_q       <= funct3_d;
         store_data_q   <= store_data_d;
         imm_q          <= imm_d;
         pc_q           <= pc_d;
         illegal_q      <= illegal_d;
      end
   end

   assign data_ready_o = data_ready_q;
   assign operation_o  = operation_q;
   assign operand1_o   = operand1_q;
   assign operand2_o   = operand2_q;
   assign rd_o         = rd_q;
   assign opcode_o     = opcode_q;
   assign funct3_o     = funct3_q;
   assign store_data_o = store_data_q;
   assign imm_o        = imm_q;
   assign pc_o         = pc_q;
   assign illegal_o    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_pipe.sv
`default_nettype none
// ============================================================================
// tb_rv32i_decode_pipe: vector table, corner sequences, random vs model. Rev 1.0
// ============================================================================
module tb_rv32i_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_ready_i, wb_valid, clear;
   logic [31:0] instruction, pc_i;
   logic [4:0]  wb_rd, rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        stall, data_ready_o, illegal;
   logic [3:0]  operation;
   logic [31:0] operand1, operand2, store_data, imm, pc_o;
   logic [4:0]  rd, opcode;
   logic [2:0]  funct3;

   logic [31:0] regs [32];
   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];

   always #5 clk = ~clk;

   rv32i_decode_pipe #(.XLEN(32), .REG_COUNT(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data_ready_i(data_ready_i),
      .instruction_i(instruction), .pc_i(pc_i), .stall_o(stall),
      .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
      .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .data_ready_o(data_ready_o),
      .operation_o(operation), .operand1_o(operand1), .operand2_o(operand2),
      .rd_o(rd), .opcode_o(opcode), .funct3_o(funct3), .store_data_o(store_data),
      .imm_o(imm), .pc_o(pc_o), .illegal_o(illegal), .clear_i(clear)
   );

   typedef struct {
      logic        dr;
      logic [3:0]  op;
      logic [31:0] op1, op2;
      logic [4:0]  rd, opc;
      logic [2:0]  f3;
      logic [31:0] sd, imm, pc;
      logic        ill;
   } out_t;

   typedef struct {
      logic [31:0] instr, pc, op1, op2, imm;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   out_t exp_out;
   bit   busy [32];
   int   hist [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      foreach (busy[r]) busy[r] = 1'b0;
      hist = '{-1, -1};
      exp_out = '{default: '0};
   endfunction

   function automatic bit uses_rs1(input logic [6:0] o);
      return !(o inside {7'h37, 7'h17, 7'h6F});
   endfunction

   function automatic bit uses_rs2(input logic [6:0] o);
      return o inside {7'h33, 7'h63, 7'h23};
   endfunction

   // Reference decode from the ISA field layout with plain masks and shifts
   function automatic out_t decode(input logic [31:0] ins, input logic [31:0] pc);
      out_t o;
      logic [2:0]  f3 = ins[14:12];
      logic [31:0] r1 = regs[ins[19:15]];
      logic [31:0] r2 = regs[ins[24:20]];
      logic [31:0] i_imm = $signed(ins) >>> 20;
      logic [31:0] s_imm = (i_imm & 32'hFFFF_FFE0) | 32'(ins[11:7]);
      logic [31:0] b_imm = (ins[31] ? 32'hFFFF_F000 : 32'h0) | (32'(ins[7]) << 11)
                         | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      logic [31:0] j_imm = (ins[31] ? 32'hFFF0_0000 : 32'h0) | (32'(ins[19:12]) << 12)
                         | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      logic [31:0] u_imm = ins & 32'hFFFF_F000;
      o = '{dr: 1'b1, op: 4'd0, op1: 32'd0, op2: 32'd0, rd: ins[11:7], opc: ins[6:2],
            f3: f3, sd: r2, imm: 32'd0, pc: pc, ill: 1'b0};
      case (ins[6:0])
         7'h33: begin o.op = {ins[30], f3}; o.op1 = r1; o.op2 = r2; end
         7'h13: begin
            o.op  = (f3 == 3'd5) ? {ins[30], 3'b101} : {1'b0, f3};
            o.op1 = r1;
            o.op2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : i_imm;
            o.imm = i_imm;
         end
         7'h37: begin o.op2 = u_imm; o.imm = u_imm; end
         7'h17: begin o.op1 = pc; o.op2 = u_imm; o.imm = u_imm; end
         7'h6F: begin o.op1 = pc; o.op2 = 32'd4; o.imm = j_imm; end
         7'h67: begin o.op1 = pc; o.op2 = 32'd4; o.imm = i_imm; end
         7'h63: begin o.op = 4'b1000; o.op1 = r1; o.op2 = r2; o.rd = 5'd0; o.imm = b_imm; end
         7'h03: begin o.op1 = r1; o.op2 = i_imm; o.imm = i_imm; end
         7'h23: begin o.op1 = r1; o.op2 = s_imm; o.imm = s_imm; o.rd = 5'd0; end
         default: begin o.ill = 1'b1; o.rd = 5'd0; end
      endcase
      return o;
   endfunction

   function automatic bit exp_stall(input bit dr, input logic [31:0] ins, input bit clr);
      logic [4:0] a = ins[19:15];
      logic [4:0] b = ins[24:20];
      if (!dr || clr) return 1'b0;
      return (uses_rs1(ins[6:0]) && a != 5'd0 && busy[a]) ||
             (uses_rs2(ins[6:0]) && b != 5'd0 && busy[b]);
   endfunction

   task automatic check_outputs();
      chk("data_ready_o", 32'(data_ready_o), 32'(exp_out.dr));
      chk("operation_o",  32'(operation),    32'(exp_out.op));
      chk("operand1_o",   operand1,          exp_out.op1);
      chk("operand2_o",   operand2,          exp_out.op2);
      chk("rd_o",         32'(rd),           32'(exp_out.rd));
      chk("opcode_o",     32'(opcode),       32'(exp_out.opc));
      chk("funct3_o",     32'(funct3),       32'(exp_out.f3));
      chk("store_data_o", store_data,        exp_out.sd);
      chk("imm_o",        imm,               exp_out.imm);
      chk("pc_o",         pc_o,              exp_out.pc);
      chk("illegal_o",    32'(illegal),      32'(exp_out.ill));
   endtask

   // One clock: drive at negedge, check stall, then check registered outputs after posedge
   task automatic cycle(input bit dr, input logic [31:0] ins, input logic [31:0] pc,
                        input bit wbv, input logic [4:0] wbr, input bit clr, output bit st);
      bit   es, iss;
      out_t d;
      @(negedge clk);
      data_ready_i = dr; instruction = ins; pc_i = pc;
      wb_valid = wbv; wb_rd = wbr; clear = clr;
      #1;
      es = exp_stall(dr, ins, clr);
      chk("stall_o", 32'(stall), 32'(es));
      st  = stall;
      iss = dr && !clr && !es;
      d   = decode(ins, pc);
      @(posedge clk);
      #1;
      if (wbv) busy[wbr] = 1'b0;
      if (clr) foreach (hist[k]) if (hist[k] > 0) busy[hist[k]] = 1'b0;
      if (iss) begin
         exp_out = d;
         if (d.rd != 5'd0) busy[d.rd] = 1'b1;
      end else begin
         exp_out.dr = 1'b0;
      end
      hist.push_front(iss ? int'(d.rd) : -1);
      if (clr) hist = '{-1, -1};
      while (hist.size() > 2) void'(hist.pop_back());
      check_outputs();
   endtask

   function automatic logic [31:0] rand_ins();
      logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                                 7'h63, 7'h03, 7'h23, 7'h7F, 7'h0F};
      logic [31:0] ins = $urandom();
      int          k   = $urandom_range(0, 10);
      ins[6:0]   = opcs[k];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      if (k >= 9) ins[19:15] = 5'd0;
      return ins;
   endfunction

   function automatic logic [4:0] pick_busy();
      int idx [$];
      for (int r = 1; r < 32; r++) if (busy[r]) idx.push_back(r);
      if (idx.size() == 0) return 5'($urandom_range(0, 7));
      return 5'(idx[$urandom_range(0, idx.size() - 1)]);
   endfunction

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [3:0] op, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [31:0] imm_v,
                               input logic [4:0] rd_v, input logic ill);
      return '{instr: instr, pc: pc, op1: op1, op2: op2, imm: imm_v, op: op, rd: rd_v, ill: ill};
   endfunction

   initial begin
      vec_t        tv [13];
      bit          st;
      bit          dr;
      bit          wbv;
      bit          clr;
      logic [31:0] ins, pc;

      foreach (regs[r]) regs[r] = (r == 0) ? 32'd0 : $urandom();
      regs[1] = 32'h11; regs[2] = 32'h22; regs[4] = 32'd10;
      regs[5] = 32'd3;  regs[7] = 32'h8000_0000;

      tv[0]  = mk(32'h405201B3, 32'h0,   4'b1000, 32'd10,        32'd3,         32'h0,         5'd3,  1'b0);
      tv[1]  = mk(32'h4043D313, 32'h0,   4'b1101, 32'h8000_0000, 32'd4,         32'h404,       5'd6,  1'b0);
      tv[2]  = mk(32'h0043D313, 32'h0,   4'b0101, 32'h8000_0000, 32'd4,         32'h4,         5'd6,  1'b0);
      tv[3]  = mk(32'h12345437, 32'h0,   4'b0000, 32'h0,         32'h1234_5000, 32'h1234_5000, 5'd8,  1'b0);
      tv[4]  = mk(32'h00001497, 32'h100, 4'b0000, 32'h100,       32'h1000,      32'h1000,      5'd9,  1'b0);
      tv[5]  = mk(32'h010000EF, 32'h200, 4'b0000, 32'h200,       32'd4,         32'd16,        5'd1,  1'b0);
      tv[6]  = mk(32'hFE208CE3, 32'h0,   4'b1000, 32'h11,        32'h22,        32'hFFFF_FFF8, 5'd0,  1'b0);
      tv[7]  = mk(32'h0000007F, 32'h0,   4'b0000, 32'h0,         32'h0,         32'h0,         5'd0,  1'b1);
      tv[8]  = mk(32'hFE522E23, 32'h0,   4'b0000, 32'd10,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 5'd0,  1'b0);
      tv[9]  = mk(32'h00822603, 32'h0,   4'b0000, 32'd10,        32'd8,         32'd8,         5'd12, 1'b0);
      tv[10] = mk(32'h005226B3, 32'h0,   4'b0010, 32'd10,        32'd3,         32'h0,         5'd13, 1'b0);
      tv[11] = mk(32'h000200E7, 32'h300, 4'b0000, 32'h300,       32'd4,         32'h0,         5'd1,  1'b0);
      tv[12] = mk(32'hFFF00093, 32'h0,   4'b0000, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b0);

      // Reset, with a reader of x1 presented: nothing is busy so no stall
      rst_n = 1'b0; data_ready_i = 1'b1; instruction = 32'h00108133; pc_i = '0;
      wb_valid = 1'b0; wb_rd = '0; clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", 32'(stall), 32'd0);
      check_outputs();
      @(negedge clk);
      data_ready_i = 1'b0;
      rst_n = 1'b1;

      foreach (tv[i]) begin
         cycle(1'b1, tv[i].instr, tv[i].pc, 1'b0, 5'd0, 1'b0, st);
         chk($sformatf("tv%0d_dr", i),  32'(data_ready_o), 32'd1);
         chk($sformatf("tv%0d_op", i),  32'(operation), 32'(tv[i].op));
         chk($sformatf("tv%0d_op1", i), operand1, tv[i].op1);
         chk($sformatf("tv%0d_op2", i), operand2, tv[i].op2);
         chk($sformatf("tv%0d_imm", i), imm, tv[i].imm);
         chk($sformatf("tv%0d_rd", i),  32'(rd), 32'(tv[i].rd));
         chk($sformatf("tv%0d_ill", i), 32'(illegal), 32'(tv[i].ill));
         cycle(1'b0, 32'h0, 32'h0, 1'b1, tv[i].rd, 1'b0, st);
      end

      // RAW hazard: addi x1 then add x2,x1,x1 waits for writeback of x1
      cycle(1'b1, 32'h00500093, 32'h400, 1'b0, 5'd0, 1'b0, st);
      chk("hz_addi_op2", operand2, 32'd5);
      chk("hz_addi_rd", 32'(rd), 32'd1);
      cycle(1'b1, 32'h00108133, 32'h404, 1'b0, 5'd0, 1'b0, st);
      chk("hz_stall1", 32'(st), 32'd1);
      cycle(1'b1, 32'h00108133, 32'h404, 1'b0, 5'd0, 1'b0, st);
      chk("hz_stall2", 32'(st), 32'd1);
      chk("hz_no_issue", 32'(data_ready_o), 32'd0);
      cycle(1'b1, 32'h00108133, 32'h404, 1'b1, 5'd1, 1'b0, st);
      chk("hz_stall_wb_cycle", 32'(st), 32'd1);
      cycle(1'b1, 32'h00108133, 32'h404, 1'b0, 5'd0, 1'b0, st);
      chk("hz_released", 32'(st), 32'd0);
      chk("hz_add_dr", 32'(data_ready_o), 32'd1);
      chk("hz_add_rd", 32'(rd), 32'd2);
      chk("hz_add_op", 32'(operation), 32'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0, st);

      // Flush drops the busy bits of both in-flight results
      cycle(1'b1, 32'h00100493, 32'h500, 1'b0, 5'd0, 1'b0, st);
      cycle(1'b1, 32'h00200513, 32'h504, 1'b0, 5'd0, 1'b0, st);
      cycle(1'b1, 32'h00A485B3, 32'h508, 1'b0, 5'd0, 1'b1, st);
      chk("fl_stall_masked", 32'(st), 32'd0);
      chk("fl_dr", 32'(data_ready_o), 32'd0);
      cycle(1'b1, 32'h00A485B3, 32'h508, 1'b0, 5'd0, 1'b0, st);
      chk("fl_add_nostall", 32'(st), 32'd0);
      chk("fl_add_rd", 32'(rd), 32'd11);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd11, 1'b0, st);

      // x0 is never busy
      cycle(1'b1, 32'h00100013, 32'h600, 1'b0, 5'd0, 1'b0, st);
      cycle(1'b1, 32'h00000733, 32'h604, 1'b0, 5'd0, 1'b0, st);
      chk("x0_nostall", 32'(st), 32'd0);
      chk("x0_rd", 32'(rd), 32'd14);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'd14, 1'b0, st);

      // Asynchronous reset while a stall is pending
      cycle(1'b1, 32'h00100793, 32'h700, 1'b0, 5'd0, 1'b0, st);
      @(negedge clk);
      data_ready_i = 1'b1; instruction = 32'h00F78833; wb_valid = 1'b0; clear = 1'b0;
      #1;
      chk("rm_stall_pre", 32'(stall), 32'd1);
      chk("rm_dr_pre", 32'(data_ready_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rm_stall_async", 32'(stall), 32'd0);
      chk("rm_dr_async", 32'(data_ready_o), 32'd0);
      model_reset();
      check_outputs();
      @(negedge clk);
      data_ready_i = 1'b0;
      rst_n = 1'b1;

      // Random traffic against the model; upstream holds while stalled
      foreach (regs[r]) regs[r] = (r == 0) ? 32'd0 : $urandom();
      st = 1'b0; dr = 1'b0; ins = '0; pc = '0;
      for (int n = 0; n < 600; n++) begin
         if (!st) begin
            dr  = ($urandom_range(0, 9) < 7);
            ins = rand_ins();
            pc  = $urandom() & 32'hFFFF_FFFC;
         end
         wbv = ($urandom_range(0, 9) < 3);
         clr = ($urandom_range(0, 19) == 0);
         cycle(dr, ins, pc, wbv, pick_busy(), clr, st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
